// File: rtl/mmio_responder_pkg.sv
// Shared constants for the MMIO responder: register offsets, control/status bit
// positions and the default base address of the I/O window.
package mmio_responder_pkg;

    localparam logic [31:0] IO_BASE_DEFAULT = 32'h0000_1000;

    localparam logic [31:0] OFF_CYCLE  = 32'd0;
    localparam logic [31:0] OFF_TCMP   = 32'd1;
    localparam logic [31:0] OFF_TCTRL  = 32'd2;
    localparam logic [31:0] OFF_LED    = 32'd3;
    localparam logic [31:0] OFF_TXDATA = 32'd4;
    localparam logic [31:0] OFF_TXSTAT = 32'd5;

    localparam int TCTRL_EN     = 0;
    localparam int TCTRL_FLAG   = 1;
    localparam int TXSTAT_FULL  = 8;
    localparam int TXSTAT_EMPTY = 9;
    localparam int TXSTAT_OVF   = 10;

endpackage

// File: rtl/mmio_responder_tx_fifo.sv
// Synchronous byte FIFO for the transmit path; a push into a full FIFO is
// accepted only when a pop frees a slot on the same edge.
module tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign overflow = push && !do_push;
    assign head     = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: head is masked while the FIFO is empty.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mmio_responder.sv
// Data-memory responder: passes RAM-range accesses through and serves the I/O
// window (cycle counter, compare timer, LEDs, TX FIFO) with one-edge read latency.
module mmio_responder
    import mmio_responder_pkg::*;
#(
    parameter logic [31:0] IO_BASE    = IO_BASE_DEFAULT,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address_dmem,
    input  logic [31:0] data,
    input  logic        wren,
    output logic [31:0] q_dmem,
    output logic [11:0] ram_address,
    output logic [31:0] ram_data,
    output logic        ram_wren,
    input  logic [31:0] ram_q,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [15:0] led,
    output logic        timer_irq
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic        is_io;
    logic [31:0] off;
    logic        wr_io;
    logic [31:0] cycle_cnt;
    logic [31:0] tcmp;
    logic        en;
    logic        flag;
    logic [15:0] led_reg;
    logic        ovf;
    logic        sel_io;
    logic [31:0] io_q;
    logic [31:0] rd_val;

    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_ovf;
    logic [CW-1:0] fifo_count;

    assign is_io = (address_dmem >= IO_BASE);
    assign off   = address_dmem - IO_BASE;
    assign wr_io = wren && is_io;

    assign ram_address = address_dmem[11:0];
    assign ram_data    = data;
    assign ram_wren    = wren && !is_io;

    assign fifo_push = wr_io && (off == OFF_TXDATA);
    assign fifo_pop  = tx_valid && tx_ready;
    assign tx_valid  = !fifo_empty;

    tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (fifo_push),
        .pop      (fifo_pop),
        .din      (data[7:0]),
        .head     (tx_data),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count),
        .overflow (fifo_ovf)
    );

    always_comb begin
        rd_val = '0;
        case (off)
            OFF_CYCLE:  rd_val = cycle_cnt;
            OFF_TCMP:   rd_val = tcmp;
            OFF_TCTRL: begin
                rd_val[TCTRL_EN]   = en;
                rd_val[TCTRL_FLAG] = flag;
            end
            OFF_LED:    rd_val[15:0] = led_reg;
            OFF_TXSTAT: begin
                rd_val[CW-1:0]       = fifo_count;
                rd_val[TXSTAT_FULL]  = fifo_full;
                rd_val[TXSTAT_EMPTY] = fifo_empty;
                rd_val[TXSTAT_OVF]   = ovf;
            end
            default:    rd_val = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cycle_cnt <= '0;
            tcmp      <= '0;
            en        <= 1'b0;
            flag      <= 1'b0;
            led_reg   <= '0;
            ovf       <= 1'b0;
            sel_io    <= 1'b0;
            io_q      <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (wr_io && off == OFF_TCMP)  tcmp    <= data;
            if (wr_io && off == OFF_TCTRL) en      <= data[TCTRL_EN];
            if (wr_io && off == OFF_LED)   led_reg <= data[15:0];
            // A match on the same edge as a clear keeps the flag set.
            if (en && cycle_cnt == tcmp)
                flag <= 1'b1;
            else if (wr_io && off == OFF_TCTRL && data[TCTRL_FLAG])
                flag <= 1'b0;
            if (fifo_ovf)
                ovf <= 1'b1;
            else if (wr_io && off == OFF_TXSTAT && data[TXSTAT_OVF])
                ovf <= 1'b0;
            sel_io <= is_io;
            io_q   <= rd_val;
        end
    end

    assign q_dmem    = sel_io ? io_q : ram_q;
    assign led       = led_reg;
    assign timer_irq = flag;

endmodule

// File: tb/tb_mmio_responder.sv
// Scoreboard bench for mmio_responder: loads and TX bytes push expectations into
// queues that a monitor drains when the DUT presents the corresponding output.
module tb_mmio_responder;

    localparam logic [31:0] IOB = 32'h0000_1000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] address_dmem = '0;
    logic [31:0] data = '0;
    logic        wren = 1'b0;
    logic [31:0] q_dmem;
    logic [11:0] ram_address;
    logic [31:0] ram_data;
    logic        ram_wren;
    logic [31:0] ram_q = '0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [15:0] led;
    logic        timer_irq;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] ld_exp_q[$];
    string       ld_name_q[$];
    logic [7:0]  tx_exp_q[$];
    logic        ld_req = 1'b0;
    logic        ld_pend = 1'b0;

    logic [31:0] ram_mem [4096];

    mmio_responder dut (
        .clock        (clock),
        .reset        (reset),
        .address_dmem (address_dmem),
        .data         (data),
        .wren         (wren),
        .q_dmem       (q_dmem),
        .ram_address  (ram_address),
        .ram_data     (ram_data),
        .ram_wren     (ram_wren),
        .ram_q        (ram_q),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .led          (led),
        .timer_irq    (timer_irq)
    );

    always #5 clock = ~clock;

    // Registered data RAM behind the responder.
    always @(posedge clock) begin
        if (ram_wren) ram_mem[ram_address] <= ram_data;
        ram_q <= ram_mem[ram_address];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: sampled mid-way between the stimulus negedge and the next posedge.
    always begin
        @(negedge clock);
        #3;
        if (ld_pend) begin
            if (ld_exp_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL load_scoreboard: load seen with no expectation queued");
            end else begin
                chk(ld_name_q.pop_front(), q_dmem, ld_exp_q.pop_front());
            end
        end
        ld_pend = ld_req;
        if (tx_valid && tx_ready) begin
            if (tx_exp_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL tx_scoreboard: byte 0x%02h popped, none expected", tx_data);
            end else begin
                chk("tx_byte", {24'd0, tx_data}, {24'd0, tx_exp_q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic idle();
        wren = 1'b0; ld_req = 1'b0;
        tick();
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        address_dmem = a; data = d; wren = 1'b1; ld_req = 1'b0;
        tick();
        wren = 1'b0;
    endtask

    task automatic load(input string name, input logic [31:0] a, input logic [31:0] exp);
        address_dmem = a; wren = 1'b0; ld_req = 1'b1;
        ld_exp_q.push_back(exp);
        ld_name_q.push_back(name);
        tick();
        ld_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) ram_mem[i] = '0;

        // Reset state
        repeat (3) tick();
        #1;
        chk("rst_led", {16'd0, led}, 32'd0);
        chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
        chk("rst_irq", {31'd0, timer_irq}, 32'd0);
        chk("rst_q_dmem", q_dmem, 32'd0);
        reset = 1'b0;
        repeat (10) idle();
        load("cycle_after_10", IOB + 0, 32'd10);

        // RAM pass-through
        address_dmem = 32'd5; data = 32'h1234; wren = 1'b1;
        #1;
        chk("ram_wren_on", {31'd0, ram_wren}, 32'd1);
        chk("ram_address", {20'd0, ram_address}, 32'd5);
        tick();
        wren = 1'b0;
        #1;
        chk("ram_wren_off", {31'd0, ram_wren}, 32'd0);
        load("ram_read5", 32'd5, 32'h0000_1234);

        // LED register
        address_dmem = IOB + 3; data = 32'hABCD_5A5A; wren = 1'b1;
        #1;
        chk("led_ram_wren", {31'd0, ram_wren}, 32'd0);
        tick();
        wren = 1'b0;
        #1;
        chk("led_out", {16'd0, led}, 32'h0000_5A5A);
        load("led_read", IOB + 3, 32'h0000_5A5A);

        // Unmapped offset and write-only TXDATA read as zero
        store(IOB + 6, 32'hFFFF_FFFF);
        load("unmapped", IOB + 6, 32'd0);
        load("txdata_read", IOB + 4, 32'd0);

        // Timer: fresh reset so the cycle count is known
        reset = 1'b1;
        tick();
        reset = 1'b0;
        store(IOB + 1, 32'd50);
        store(IOB + 2, 32'd1);
        repeat (48) idle();
        #1;
        chk("irq_before_match", {31'd0, timer_irq}, 32'd0);
        idle();
        #1;
        chk("irq_at_match", {31'd0, timer_irq}, 32'd1);
        store(IOB + 1, 32'd60);
        repeat (8) idle();
        store(IOB + 2, 32'd2);
        #1;
        chk("irq_set_beats_clear", {31'd0, timer_irq}, 32'd1);
        store(IOB + 2, 32'd2);
        #1;
        chk("irq_cleared", {31'd0, timer_irq}, 32'd0);
        load("tctrl_read", IOB + 2, 32'd0);

        // FIFO overflow then drain
        tx_ready = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            store(IOB + 4, 32'(i));
            if (i <= 8) tx_exp_q.push_back(8'(i));
        end
        load("txstat_full_ovf", IOB + 5, 32'h0000_0508);
        tx_ready = 1'b1;
        repeat (8) idle();
        tx_ready = 1'b0;
        #1;
        chk("drained_tx_valid", {31'd0, tx_valid}, 32'd0);
        load("txstat_empty_ovf", IOB + 5, 32'h0000_0600);
        store(IOB + 5, 32'h0000_0400);
        load("txstat_ovf_clr", IOB + 5, 32'h0000_0200);

        // Full FIFO with simultaneous push and pop
        for (int i = 0; i < 8; i++) begin
            store(IOB + 4, 32'h10 + 32'(i));
            tx_exp_q.push_back(8'h10 + 8'(i));
        end
        tx_ready = 1'b1;
        store(IOB + 4, 32'h18);
        tx_exp_q.push_back(8'h18);
        tx_ready = 1'b0;
        load("txstat_full_pushpop", IOB + 5, 32'h0000_0108);
        tx_ready = 1'b1;
        repeat (8) idle();
        tx_ready = 1'b0;
        #1;
        chk("pushpop_drained", {31'd0, tx_valid}, 32'd0);
        chk("tx_queue_empty", 32'(tx_exp_q.size()), 32'd0);

        // Mid-operation reset with FIFO contents and flag set
        reset = 1'b1;
        tick();
        reset = 1'b0;
        store(IOB + 1, 32'd5);
        store(IOB + 2, 32'd1);
        store(IOB + 4, 32'hA1);
        store(IOB + 4, 32'hA2);
        store(IOB + 4, 32'hA3);
        idle();
        #1;
        chk("pre_rst_irq", {31'd0, timer_irq}, 32'd1);
        chk("pre_rst_tx_head", {24'd0, tx_data}, 32'h0000_00A1);
        load("pre_rst_tctrl", IOB + 2, 32'd3);
        reset = 1'b1;
        tick();
        #1;
        chk("post_rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("post_rst_irq", {31'd0, timer_irq}, 32'd0);
        reset = 1'b0;
        load("post_rst_cycle", IOB + 0, 32'd0);
        load("post_rst_txstat", IOB + 5, 32'h0000_0200);
        repeat (2) idle();
        chk("ld_queue_empty", 32'(ld_exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mmio_responder.md
# mmio_responder

Memory-side responder for the processor's data-memory port. It decodes every load/store, forwards RAM-range accesses to the data RAM unchanged, and serves an I/O window itself. The I/O window holds a free-running cycle counter, a compare timer with interrupt flag, an LED register and an 8-deep byte transmit FIFO with a valid/ready output. It sits between the processor's dmem pins and the data RAM, inside the top-level wrapper.

## Interface
- IO_BASE, 32'h0000_1000, word address of the first I/O register; addresses ≥ IO_BASE are I/O, all lower addresses are RAM.
- FIFO_DEPTH, 8, TX FIFO entries; must be a power of two, 2..16.

Ports:
- clock  in  1  master clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- address_dmem  in  32  word address from the processor.
- data  in  32  store data from the processor.
- wren  in  1  store strobe from the processor.
- q_dmem  out  32  load data to the processor.
- ram_address  out  12  equals address_dmem[11:0].
- ram_data  out  32  equals data.
- ram_wren  out  1  equals wren && (address_dmem < IO_BASE).
- ram_q  in  32  registered RAM read data.
- tx_data  out  8  head byte of the TX FIFO.
- tx_valid  out  1  FIFO non-empty.
- tx_ready  in  1  consumer accepts the head byte.
- led  out  16  LED register.
- timer_irq  out  1  timer flag.

## Operation
Word offsets from IO_BASE:
- +0 CYCLE, RO: 32-bit counter, +1 every cycle, wraps 0xFFFF_FFFF→0.
- +1 TCMP, RW: compare value.
- +2 TCTRL:
  - bit0 EN, RW.
  - bit1 FLAG, RO; writing 1 clears it.
  - other bits read 0.
- +3 LED, RW: bits[15:0]; upper bits read 0.
- +4 TXDATA, WO: a store pushes data[7:0]. When the FIFO is full, the byte is dropped and OVF is set. Reads return 0.
- +5 TXSTAT:
  - [4:0] count.
  - bit8 full.
  - bit9 empty.
  - bit10 OVF, sticky; writing 1 to bit10 clears it.
- Any other offset ≥ +6: reads return 0, writes are ignored.

Timer:
- FLAG sets on a rising edge where EN=1 and CYCLE==TCMP (value before the increment).
- If set and clear occur in the same cycle, set wins.

FIFO:
- tx_data is the head entry.
- Pop occurs when tx_valid && tx_ready.
- Push and pop in the same cycle are both performed: count is unchanged, including when full.
- Pop while empty is impossible, because tx_valid=0.

Read path:
- On each rising edge, register sel_io = (address_dmem ≥ IO_BASE) and io_q = the I/O register selected by the current address (CYCLE samples its pre-increment value).
- q_dmem = sel_io ? io_q : ram_q.

## Timing
- Load latency is one rising edge. Address and wren are presented after the processor's falling-edge update. q_dmem is valid after the next rising edge and holds until the following rising edge, which is before the processor's next falling-edge capture.
- Stores take effect at the rising edge where wren=1. A load of the same register in the next access sees the new value.
- Register writes are idempotent, so a processor stall that holds wren high for several cycles rewrites the same value. Exception: TXDATA pushes once per cycle that wren=1 with that address. Software must not stall on TXDATA stores; the bench checks the per-cycle behaviour.
- Reset values:
  - CYCLE=0, TCMP=0, EN=0, FLAG=0, LED=0.
  - FIFO empty, OVF=0.
  - io_q=0, sel_io=0.
  - Outputs: q_dmem=ram_q, tx_valid=0, tx_data=0, led=0, timer_irq=0.
- Reset asserted mid-operation discards all FIFO contents, pending counts and the flag on that edge. Reset overrides any simultaneous write.

## Structure
- Shared package holds the register offset constants (OFF_CYCLE..OFF_TXSTAT), the TCTRL/TXSTAT bit positions, and the default IO_BASE.
- One sub-module is natural: tx_fifo (synchronous FIFO with push/pop/full/empty/count, parameterised by depth). The decode logic, registers and timer stay in mmio_responder.

## Test plan
- Reset, then idle for 10 cycles → load from IO_BASE+0 returns 10 (±1 per the documented sample point); led=0; tx_valid=0.
- Store 0x1234 to address 5, load address 5 → ram_wren pulses for one cycle, q_dmem=0x1234 from ram_q. Store to IO_BASE+3 with value 0xABCD_5A5A → led=0x5A5A, ram_wren stays 0, readback is 0x0000_5A5A.
- TCMP=50, EN=1 → timer_irq rises the cycle after CYCLE==50. Store 2 to TCTRL on the same cycle as a new match → FLAG stays 1. Store 2 on a non-matching cycle → timer_irq=0.
- With tx_ready=0, push 9 bytes 0x01..0x09 → TXSTAT reads count=8, full=1, OVF=1; byte 0x09 is lost. Raise tx_ready → 0x01..0x08 appear in order, then empty=1 and tx_valid=0.
- FIFO full with tx_ready=1 and a push in the same cycle → count stays 8, OVF stays 0, and the new byte emerges last.
- Reset asserted while the FIFO holds 3 bytes and FLAG=1 → next cycle tx_valid=0, timer_irq=0, CYCLE restarts at 0.
